// File: rtl/hazard_if.sv
// Pipeline <-> hazard controller bundle: hazard-detection inputs from the datapath
// and the enables, flushes, hold and status the controller returns.
interface hazard_if #(
    parameter int CNT_W = 16
);
    // Pure level signals, no handshake: the datapath presents the ID/EX/MEM state every
    // cycle and the controller answers combinationally in that same cycle.
    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_rd;
    logic [4:0]       IF_ID_rs1;
    logic [4:0]       IF_ID_rs2;
    logic             branch_taken;
    logic             mem_busy;
    logic             halt_req;

    logic             PCWrite;
    logic             IF_ID_Write;
    logic             Mux_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             EX_MEM_Flush;
    logic             pipe_hold;
    logic             halted;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ID_EX_MemRead, ID_EX_rd, IF_ID_rs1, IF_ID_rs2,
               branch_taken, mem_busy, halt_req,
        input  PCWrite, IF_ID_Write, Mux_Write,
               IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
               pipe_hold, halted, mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_rd, IF_ID_rs1, IF_ID_rs2,
               branch_taken, mem_busy, halt_req,
        output PCWrite, IF_ID_Write, Mux_Write,
               IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
               pipe_hold, halted, mem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_controller.sv
// Five-stage pipeline hazard controller: load-use stalls, branch flushes, memory-wait
// hold with timeout, and halt drain. Control outputs are Mealy on state plus inputs.
module hazard_controller #(
    parameter int DRAIN_CYCLES = 3,
    parameter int TIMEOUT      = 255,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    hazard_if.slave    bus,
    output logic [1:0] dbg_state
);
    localparam int WAIT_W  = 10;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_WAIT   = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [WAIT_W-1:0]  wait_next;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [DRAIN_W-1:0] drain_next;
    logic [CNT_W-1:0]   stall_q;
    logic [CNT_W-1:0]   flush_q;
    logic               timeout_q;
    logic               stall_inc;
    logic               flush_inc;
    logic               timeout_set;
    logic               run_rules;
    logic               hazard;

    assign hazard = bus.ID_EX_MemRead && (bus.ID_EX_rd != 5'd0) &&
                    ((bus.ID_EX_rd == bus.IF_ID_rs1) || (bus.ID_EX_rd == bus.IF_ID_rs2));

    always_comb begin
        bus.PCWrite      = 1'b1;
        bus.IF_ID_Write  = 1'b1;
        bus.Mux_Write    = 1'b1;
        bus.IF_ID_Flush  = 1'b0;
        bus.ID_EX_Flush  = 1'b0;
        bus.EX_MEM_Flush = 1'b0;
        bus.pipe_hold    = 1'b0;
        bus.halted       = 1'b0;
        state_next       = state;
        wait_next        = wait_cnt;
        drain_next       = drain_cnt;
        stall_inc        = 1'b0;
        flush_inc        = 1'b0;
        timeout_set      = 1'b0;
        run_rules        = 1'b0;

        // While reset is high every input is treated as 0, leaving the RUN defaults.
        if (!reset) begin
            unique case (state)
                S_RUN: run_rules = 1'b1;

                S_WAIT: begin
                    if (bus.mem_busy && !bus.branch_taken) begin
                        bus.PCWrite     = 1'b0;
                        bus.IF_ID_Write = 1'b0;
                        bus.pipe_hold   = 1'b1;
                        wait_next       = wait_cnt + WAIT_W'(1);
                        if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                            timeout_set = 1'b1;
                            state_next  = S_HALTED;
                        end
                    end else begin
                        wait_next = '0;
                        run_rules = 1'b1;
                    end
                end

                S_DRAIN: begin
                    if (bus.branch_taken) begin
                        // The halt was on the wrong path: squash it and resume.
                        bus.IF_ID_Flush  = 1'b1;
                        bus.ID_EX_Flush  = 1'b1;
                        bus.EX_MEM_Flush = 1'b1;
                        flush_inc        = 1'b1;
                        state_next       = S_RUN;
                    end else begin
                        bus.PCWrite     = 1'b0;
                        bus.IF_ID_Flush = 1'b1;
                        bus.Mux_Write   = 1'b0;
                        if (bus.mem_busy) begin
                            bus.pipe_hold = 1'b1;
                        end else if (drain_cnt == '0) begin
                            state_next = S_HALTED;
                        end else begin
                            drain_next = drain_cnt - DRAIN_W'(1);
                        end
                    end
                end

                S_HALTED: begin
                    bus.PCWrite     = 1'b0;
                    bus.IF_ID_Write = 1'b0;
                    bus.Mux_Write   = 1'b0;
                    bus.pipe_hold   = 1'b1;
                    bus.halted      = 1'b1;
                end
            endcase

            if (run_rules) begin
                state_next = S_RUN;
                if (bus.branch_taken) begin
                    bus.IF_ID_Flush  = 1'b1;
                    bus.ID_EX_Flush  = 1'b1;
                    bus.EX_MEM_Flush = 1'b1;
                    flush_inc        = 1'b1;
                end else if (bus.mem_busy) begin
                    bus.PCWrite     = 1'b0;
                    bus.IF_ID_Write = 1'b0;
                    bus.pipe_hold   = 1'b1;
                    wait_next       = '0;
                    state_next      = S_WAIT;
                end else if (bus.halt_req) begin
                    bus.PCWrite     = 1'b0;
                    bus.IF_ID_Flush = 1'b1;
                    drain_next      = DRAIN_W'(DRAIN_CYCLES - 1);
                    state_next      = S_DRAIN;
                end else if (hazard) begin
                    bus.PCWrite     = 1'b0;
                    bus.IF_ID_Write = 1'b0;
                    bus.Mux_Write   = 1'b0;
                    stall_inc       = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_RUN;
            wait_cnt  <= '0;
            drain_cnt <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_next;
            drain_cnt <= drain_next;
            if (stall_inc && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_inc && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.stall_cnt   = stall_q;
    assign bus.flush_cnt   = flush_q;
    assign bus.mem_timeout = timeout_q;
    assign dbg_state       = state;
endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (DRAIN_CYCLES=3, TIMEOUT=8, CNT_W=4).
// Control vector order: PCWrite IF_ID_Write Mux_Write | IF_ID_Flush ID_EX_Flush EX_MEM_Flush | pipe_hold halted mem_timeout.
module tb_hazard_controller;
    localparam logic [8:0] C_DEF    = 9'b111_000_000;
    localparam logic [8:0] C_STALL  = 9'b000_000_000;
    localparam logic [8:0] C_FLUSH  = 9'b111_111_000;
    localparam logic [8:0] C_BUSY   = 9'b001_000_100;
    localparam logic [8:0] C_HREQ   = 9'b011_100_000;
    localparam logic [8:0] C_DRAIN  = 9'b010_100_000;
    localparam logic [8:0] C_DRBUSY = 9'b010_100_100;
    localparam logic [8:0] C_HALT   = 9'b000_000_110;
    localparam logic [8:0] C_HALTTO = 9'b000_000_111;

    localparam logic [1:0] ST_RUN = 2'd0, ST_WAIT = 2'd1, ST_DRAIN = 2'd2, ST_HALTED = 2'd3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dbg_state;
    int         checks = 0;
    int         errors = 0;

    hazard_if #(.CNT_W(4)) bus ();

    hazard_controller #(
        .DRAIN_CYCLES(3),
        .TIMEOUT(8),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] ctl();
        return {bus.PCWrite, bus.IF_ID_Write, bus.Mux_Write,
                bus.IF_ID_Flush, bus.ID_EX_Flush, bus.EX_MEM_Flush,
                bus.pipe_hold, bus.halted, bus.mem_timeout};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ID_EX_MemRead = 1'b0;
        bus.ID_EX_rd      = 5'd0;
        bus.IF_ID_rs1     = 5'd0;
        bus.IF_ID_rs2     = 5'd0;
        bus.branch_taken  = 1'b0;
        bus.mem_busy      = 1'b0;
        bus.halt_req      = 1'b0;
    endtask

    task automatic set_hazard(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        bus.ID_EX_MemRead = 1'b1;
        bus.ID_EX_rd      = rd;
        bus.IF_ID_rs1     = rs1;
        bus.IF_ID_rs2     = rs2;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        chk("rst_ctl", 16'(ctl()), 16'(C_DEF));
        chk("rst_state", 16'(dbg_state), 16'(ST_RUN));
        chk("rst_stall", 16'(bus.stall_cnt), 16'd0);
        chk("rst_flush", 16'(bus.flush_cnt), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        // Inputs during reset must be ignored.
        bus.branch_taken = 1'b1;
        bus.mem_busy     = 1'b1;
        set_hazard(5'd2, 5'd2, 5'd0);
        #12;
        chk("reset_ctl", 16'(ctl()), 16'(C_DEF));
        chk("reset_state", 16'(dbg_state), 16'(ST_RUN));
        chk("reset_cnts", 16'({bus.stall_cnt, bus.flush_cnt}), 16'd0);
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Load-use on rs2
        set_hazard(5'd5, 5'd0, 5'd5);
        #1;
        chk("lu_rs2_ctl", 16'(ctl()), 16'(C_STALL));
        tick();
        clear_inputs();
        #1;
        chk("lu_one_cycle", 16'(ctl()), 16'(C_DEF));
        chk("lu_stall_cnt", 16'(bus.stall_cnt), 16'd1);
        // rd = x0 never stalls
        set_hazard(5'd0, 5'd0, 5'd0);
        #1;
        chk("lu_x0_ctl", 16'(ctl()), 16'(C_DEF));
        tick();
        chk("lu_x0_cnt", 16'(bus.stall_cnt), 16'd1);
        // rs1 match, then no match
        set_hazard(5'd7, 5'd7, 5'd3);
        #1;
        chk("lu_rs1_ctl", 16'(ctl()), 16'(C_STALL));
        tick();
        set_hazard(5'd7, 5'd6, 5'd8);
        #1;
        chk("lu_nomatch_ctl", 16'(ctl()), 16'(C_DEF));
        tick();
        chk("lu_cnt2", 16'(bus.stall_cnt), 16'd2);

        // Branch beats mem_busy, halt_req and hazard
        set_hazard(5'd3, 5'd3, 5'd0);
        bus.branch_taken = 1'b1;
        bus.mem_busy     = 1'b1;
        bus.halt_req     = 1'b1;
        #1;
        chk("br_prio_ctl", 16'(ctl()), 16'(C_FLUSH));
        tick();
        clear_inputs();
        #1;
        chk("br_state", 16'(dbg_state), 16'(ST_RUN));
        chk("br_flush_cnt", 16'(bus.flush_cnt), 16'd1);
        chk("br_stall_cnt", 16'(bus.stall_cnt), 16'd2);

        // mem_busy for 4 cycles; on release a hazard is evaluated in the same cycle
        bus.mem_busy = 1'b1;
        #1;
        chk("mb_c1_ctl", 16'(ctl()), 16'(C_BUSY));
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("mb_wait_state", 16'(dbg_state), 16'(ST_WAIT));
            chk("mb_wait_ctl", 16'(ctl()), 16'(C_BUSY));
            tick();
        end
        bus.mem_busy = 1'b0;
        set_hazard(5'd4, 5'd1, 5'd4);
        #1;
        chk("mb_rel_state", 16'(dbg_state), 16'(ST_WAIT));
        chk("mb_rel_ctl", 16'(ctl()), 16'(C_STALL));
        tick();
        clear_inputs();
        #1;
        chk("mb_run_state", 16'(dbg_state), 16'(ST_RUN));
        chk("mb_run_ctl", 16'(ctl()), 16'(C_DEF));
        chk("mb_stall_cnt", 16'(bus.stall_cnt), 16'd3);

        // Halt: 3 drain cycles, hazard ignored while draining
        bus.halt_req = 1'b1;
        #1;
        chk("halt_req_ctl", 16'(ctl()), 16'(C_HREQ));
        tick();
        clear_inputs();
        set_hazard(5'd9, 5'd9, 5'd9);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("drain_state", 16'(dbg_state), 16'(ST_DRAIN));
            chk("drain_ctl", 16'(ctl()), 16'(C_DRAIN));
            tick();
        end
        chk("halt_state", 16'(dbg_state), 16'(ST_HALTED));
        chk("halt_ctl", 16'(ctl()), 16'(C_HALT));
        bus.branch_taken = 1'b1;
        bus.mem_busy     = 1'b1;
        bus.halt_req     = 1'b1;
        #1;
        chk("halt_ign_ctl", 16'(ctl()), 16'(C_HALT));
        tick();
        chk("halt_ign_state", 16'(dbg_state), 16'(ST_HALTED));
        chk("halt_ign_cnts", 16'({bus.stall_cnt, bus.flush_cnt}), 16'h31);
        clear_inputs();
        pulse_reset();

        // Halt with mem_busy in the first two drain cycles: halted two cycles later
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.mem_busy = (i < 2);
            #1;
            chk("drbusy_state", 16'(dbg_state), 16'(ST_DRAIN));
            chk("drbusy_ctl", 16'(ctl()), 16'((i < 2) ? C_DRBUSY : C_DRAIN));
            tick();
        end
        chk("drbusy_halted", 16'(ctl()), 16'(C_HALT));
        pulse_reset();

        // Halt squashed by a branch in the second drain cycle
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        tick();
        bus.branch_taken = 1'b1;
        #1;
        chk("drbr_ctl", 16'(ctl()), 16'(C_FLUSH));
        tick();
        clear_inputs();
        #1;
        chk("drbr_state", 16'(dbg_state), 16'(ST_RUN));
        chk("drbr_ctl_after", 16'(ctl()), 16'(C_DEF));
        chk("drbr_flush_cnt", 16'(bus.flush_cnt), 16'd1);

        // Timeout: RUN cycle, then 8 wait counts, then HALTED with mem_timeout
        bus.mem_busy = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("to_wait_state", 16'(dbg_state), 16'(ST_WAIT));
            chk("to_wait_ctl", 16'(ctl()), 16'(C_BUSY));
            tick();
        end
        chk("to_state", 16'(dbg_state), 16'(ST_HALTED));
        chk("to_ctl", 16'(ctl()), 16'(C_HALTTO));
        bus.mem_busy = 1'b0;
        tick();
        chk("to_sticky", 16'(ctl()), 16'(C_HALTTO));
        pulse_reset();
        chk("to_cleared", 16'(ctl()), 16'(C_DEF));

        // Saturation: 17 consecutive hazard cycles with a 4-bit counter
        set_hazard(5'd12, 5'd12, 5'd1);
        for (int i = 0; i < 15; i++) tick();
        chk("sat_15", 16'(bus.stall_cnt), 16'd15);
        tick();
        tick();
        chk("sat_17", 16'(bus.stall_cnt), 16'd15);
        clear_inputs();

        // Reset in the middle of a drain
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        tick();
        chk("mid_drain_state", 16'(dbg_state), 16'(ST_DRAIN));
        pulse_reset();
        chk("post_rst_state", 16'(dbg_state), 16'(ST_RUN));
        chk("post_rst_ctl", 16'(ctl()), 16'(C_DEF));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
